// File: rtl/nibble_adder_pkg.sv
// nibble_adder_pkg
// Shared definitions for the nibble-serial adder: FSM state encoding, the
// nibble width, and the helper that sizes the nibble index register.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Bits needed to index WIDTH/NIBBLE_W nibbles (at least 1).
  function automatic int idx_width(input int width);
    int n;
    int w;
    n = width / NIBBLE_W;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/cla4.sv
// cla4
// The 4-bit carry-lookahead adder.
// Ports: A, B (4-bit addends), C_IN (carry-in) -> SUM (4-bit), C_OUT (carry-out).
module cla4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_IN,
  output logic [3:0] SUM,
  output logic       C_OUT
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = A ^ B;
  assign w_g = A & B;

  // Every carry is formed directly from generate/propagate terms.
  assign w_c[0] = C_IN;
  assign w_c[1] = w_g[0] | (w_p[0] & C_IN);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & C_IN);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & C_IN);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & C_IN);

  assign SUM   = w_p ^ w_c[3:0];
  assign C_OUT = w_c[4];

endmodule

// File: rtl/nibble_serial_adder_stage.sv
// nibble_serial_adder_stage
// One nibble of addition per cycle through the 4-bit CLA. When
// NIBBLE_SERIAL_SELFCHECK_EN is defined, a ripple-carry reference adder runs
// on the same inputs and MISMATCH flags any disagreement (combinational).
// Ports: A, B, C_IN (nibble inputs) -> SUM, C_OUT (CLA result),
//        MISMATCH (only with NIBBLE_SERIAL_SELFCHECK_EN).
module nibble_serial_adder_stage
  import nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                C_IN,
  output logic [NIBBLE_W-1:0] SUM,
  output logic                C_OUT
`ifdef NIBBLE_SERIAL_SELFCHECK_EN
  ,
  output logic                MISMATCH
`endif
);

  cla4 u_cla (
    .A    (A),
    .B    (B),
    .C_IN (C_IN),
    .SUM  (SUM),
    .C_OUT(C_OUT)
  );

`ifdef NIBBLE_SERIAL_SELFCHECK_EN
  logic [NIBBLE_W-1:0] w_ref_sum;
  logic                w_ref_cout;

  rca4 u_rca (
    .A    (A),
    .B    (B),
    .C_IN (C_IN),
    .SUM  (w_ref_sum),
    .C_OUT(w_ref_cout)
  );

  assign MISMATCH = (w_ref_sum != SUM) || (w_ref_cout != C_OUT);
`endif

endmodule

// File: rtl/rca4.sv
// rca4
// The 4-bit ripple-carry adder, used as an independent reference.
// Ports: A, B (4-bit addends), C_IN (carry-in) -> SUM (4-bit), C_OUT (carry-out).
module rca4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_IN,
  output logic [3:0] SUM,
  output logic       C_OUT
);

  logic [4:0] w_c;

  assign w_c[0] = C_IN;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign SUM[i]   = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign C_OUT = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
// WIDTH-bit adder computed one nibble per clock through a single 4-bit adder
// stage, with the carry registered between nibbles. START/DONE handshake;
// START in FIN is accepted for back-to-back operation.
// Optional macro: NIBBLE_SERIAL_SELFCHECK_EN (reference adder + sticky MISMATCH).
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   START         request (accepted in IDLE or FIN)
//   A, B, C_IN    operands, captured on accept
//   BUSY          high in RUN
//   DONE          one-cycle pulse when the result is valid
//   SUM, C_OUT    registered result and unsigned carry-out
//   OVF           signed overflow
//   MISMATCH      sticky self-check error (0 when the macro is undefined)
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             C_OUT,
  output logic             OVF,
  output logic             MISMATCH
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t r_state;
  state_t w_next;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_a;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_b;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_sum;
  logic                             r_carry;
  logic [IDX_W-1:0]                 r_idx;
  logic                             r_cout;
  logic                             r_ovf;

  logic                w_accept;
  logic                w_last;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum_nib;
  logic                w_cout_nib;
  logic                w_msb_cin;

  assign w_accept = START && ((r_state == IDLE) || (r_state == FIN));
  assign w_last   = (r_idx == LAST_IDX);
  assign w_a_nib  = r_a[r_idx];
  assign w_b_nib  = r_b[r_idx];

  // Carry into the top bit of the nibble, recovered from its sum bit.
  assign w_msb_cin = w_a_nib[NIBBLE_W-1] ^ w_b_nib[NIBBLE_W-1] ^ w_sum_nib[NIBBLE_W-1];

`ifdef NIBBLE_SERIAL_SELFCHECK_EN
  logic w_stage_mis;
  logic r_mismatch;

  nibble_serial_adder_stage u_stage (
    .A       (w_a_nib),
    .B       (w_b_nib),
    .C_IN    (r_carry),
    .SUM     (w_sum_nib),
    .C_OUT   (w_cout_nib),
    .MISMATCH(w_stage_mis)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mismatch <= 1'b0;
    end else if ((r_state == RUN) && w_stage_mis) begin
      r_mismatch <= 1'b1;
    end
  end

  assign MISMATCH = r_mismatch;
`else
  nibble_serial_adder_stage u_stage (
    .A    (w_a_nib),
    .B    (w_b_nib),
    .C_IN (r_carry),
    .SUM  (w_sum_nib),
    .C_OUT(w_cout_nib)
  );

  assign MISMATCH = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (START) w_next = RUN;
      RUN:     if (w_last) w_next = FIN;
      FIN:     w_next = START ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and per-nibble result assembly
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_sum   <= '0;
      r_carry <= C_IN;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == RUN) begin
      r_sum[r_idx] <= w_sum_nib;
      r_carry      <= w_cout_nib;
      if (w_last) begin
        r_cout <= w_cout_nib;
        r_ovf  <= w_msb_cin ^ w_cout_nib;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign BUSY  = (r_state == RUN);
  assign DONE  = (r_state == FIN);
  assign SUM   = r_sum;
  assign C_OUT = r_cout;
  assign OVF   = r_ovf;

endmodule
